perf_window_ctrl: RTL and testbench

- Sampling-window scheduler for the bus performance monitor.
- Sequences measurement windows by clearing the counters, enabling them for a programmed number of cycles, then raising a snapshot request to the register/readout side.
- Repeats for a programmed window count or continuously, then flags completion via interrupt.
- Sits between the AXI config register file, which supplies cfg_* and consumes snap_*, and the perf counter datapath, which consumes cnt_en_o and cnt_clr_o.

---
 rtl/perf_mon_pkg.sv | 22 ++
 rtl/perf_win_timer.sv | 35 +++
 rtl/perf_window_ctrl.sv | 163 ++++++++++++++++
 tb/tb_perf_window_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_mon_pkg.sv
// Shared types and default widths for the bus performance monitor window scheduler.
package perf_mon_pkg;

  localparam int WIN_WIDTH_DEF = 32;
  localparam int NUM_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    SNAP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Sized for the default widths; instances must not exceed them.
  typedef struct packed {
    logic [NUM_WIDTH_DEF-1:0] idx;
    logic [WIN_WIDTH_DEF-1:0] len;
    logic                     partial;
  } snap_info_t;

endpackage

// File: rtl/perf_win_timer.sv
// Window timer: loadable down-counter with zero flag, plus an elapsed-cycle up-counter.
module perf_win_timer
  import perf_mon_pkg::*;
#(
  parameter int WIN_WIDTH = WIN_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [WIN_WIDTH-1:0] load_val_i,
  input  logic                 run_i,
  output logic                 zero_o,
  output logic [WIN_WIDTH-1:0] elapsed_o
);

  logic [WIN_WIDTH-1:0] timer_q;
  logic [WIN_WIDTH-1:0] elapsed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      elapsed_q <= '0;
    end else if (load_i) begin
      timer_q   <= load_val_i;
      elapsed_q <= '0;
    end else if (run_i) begin
      elapsed_q <= elapsed_q + WIN_WIDTH'(1);
      if (timer_q != '0) timer_q <= timer_q - WIN_WIDTH'(1);
    end
  end

  assign zero_o    = (timer_q == '0);
  assign elapsed_o = elapsed_q;

endmodule

// File: rtl/perf_window_ctrl.sv
// Sampling-window scheduler: clear, count for win_len cycles, request a snapshot, repeat.
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | one-cycle counter clear, timer load
//   RUN   | counters enabled, timer running
//   SNAP  | snapshot request held until accepted
//   DONE  | one cycle, raises irq
module perf_window_ctrl
  import perf_mon_pkg::*;
#(
  parameter int WIN_WIDTH = WIN_WIDTH_DEF,
  parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_start_i,
  input  logic                 cfg_stop_i,
  input  logic [WIN_WIDTH-1:0] cfg_win_len_i,
  input  logic [NUM_WIDTH-1:0] cfg_num_win_i,
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  output logic                 snap_valid_o,
  input  logic                 snap_ready_i,
  output logic [NUM_WIDTH-1:0] snap_idx_o,
  output logic [WIN_WIDTH-1:0] snap_len_o,
  output logic                 snap_partial_o,
  output logic                 busy_o,
  output logic                 cfg_err_o,
  output logic                 irq_o,
  input  logic                 irq_clr_i
);

  state_t               state_q, state_d;
  logic [NUM_WIDTH-1:0] win_idx_q, win_idx_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [WIN_WIDTH-1:0] win_len_q;
  logic [NUM_WIDTH-1:0] num_win_q;
  snap_info_t           snap_q, snap_d;
  logic                 latch_cfg;
  logic                 tmr_load, tmr_run, tmr_zero;
  logic [WIN_WIDTH-1:0] tmr_elapsed;
  logic                 err_set, irq_set;
  logic                 stop_now, last_win;
  logic                 en_q, clr_q, valid_q, busy_q, err_q, irq_q;

  perf_win_timer #(
    .WIN_WIDTH(WIN_WIDTH)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .load_val_i(win_len_q - WIN_WIDTH'(1)),
    .run_i     (tmr_run),
    .zero_o    (tmr_zero),
    .elapsed_o (tmr_elapsed)
  );

  assign stop_now = stop_pend_q | cfg_stop_i;
  assign last_win = (num_win_q != '0) && (win_idx_q == num_win_q - NUM_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    win_idx_d   = win_idx_q;
    stop_pend_d = stop_pend_q;
    snap_d      = snap_q;
    latch_cfg   = 1'b0;
    tmr_load    = 1'b0;
    tmr_run     = 1'b0;
    err_set     = 1'b0;

    case (state_q)
      IDLE: begin
        // Stop in the same cycle as start cancels the start outright.
        if (cfg_start_i && !cfg_stop_i) begin
          if (cfg_win_len_i != '0) begin
            latch_cfg   = 1'b1;
            win_idx_d   = '0;
            stop_pend_d = 1'b0;
            state_d     = CLEAR;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      CLEAR: begin
        tmr_load    = 1'b1;
        stop_pend_d = stop_now;
        state_d     = stop_now ? DONE : RUN;
      end
      RUN: begin
        tmr_run = 1'b1;
        if (cfg_stop_i) stop_pend_d = 1'b1;
        if (tmr_zero || cfg_stop_i) begin
          state_d        = SNAP;
          snap_d.idx     = NUM_WIDTH_DEF'(win_idx_q);
          snap_d.len     = WIN_WIDTH_DEF'(tmr_elapsed + WIN_WIDTH'(1));
          snap_d.partial = cfg_stop_i && !tmr_zero;
        end
      end
      SNAP: begin
        if (cfg_stop_i) stop_pend_d = 1'b1;
        if (snap_ready_i) begin
          if (stop_now || last_win) begin
            state_d = DONE;
          end else begin
            win_idx_d = win_idx_q + NUM_WIDTH'(1);
            state_d   = CLEAR;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    irq_set = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      win_idx_q   <= '0;
      stop_pend_q <= 1'b0;
      win_len_q   <= '0;
      num_win_q   <= '0;
      snap_q      <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_idx_q   <= win_idx_d;
      stop_pend_q <= stop_pend_d;
      snap_q      <= snap_d;
      if (latch_cfg) begin
        win_len_q <= cfg_win_len_i;
        num_win_q <= cfg_num_win_i;
      end
      en_q    <= (state_d == RUN);
      clr_q   <= (state_d == CLEAR);
      valid_q <= (state_d == SNAP);
      busy_q  <= (state_d != IDLE);
      // A set landing together with irq_clr_i takes priority.
      if (err_set)        err_q <= 1'b1;
      else if (irq_clr_i) err_q <= 1'b0;
      if (irq_set)        irq_q <= 1'b1;
      else if (irq_clr_i) irq_q <= 1'b0;
    end
  end

  assign cnt_en_o       = en_q;
  assign cnt_clr_o      = clr_q;
  assign snap_valid_o   = valid_q;
  assign snap_idx_o     = snap_q.idx[NUM_WIDTH-1:0];
  assign snap_len_o     = snap_q.len[WIN_WIDTH-1:0];
  assign snap_partial_o = snap_q.partial;
  assign busy_o         = busy_q;
  assign cfg_err_o      = err_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Directed bench for perf_window_ctrl: per-cycle vector table plus multi-cycle corner sequences.
module tb_perf_window_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, ready = 1'b0, iclr = 1'b0;
  logic [31:0] win_len = 32'd0;
  logic [15:0] num_win = 16'd0;
  logic        en, clr, val, part, busy, err, irq;
  logic [15:0] idx;
  logic [31:0] len;

  logic        w_start = 1'b0, w_stop = 1'b0, w_ready = 1'b1, w_iclr = 1'b0;
  logic [31:0] w_win_len = 32'd1;
  logic [1:0]  w_num_win = 2'd0;
  logic        w_en, w_clr, w_val, w_part, w_busy, w_err, w_irq;
  logic [1:0]  w_idx;
  logic [31:0] w_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_window_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start), .cfg_stop_i(stop),
    .cfg_win_len_i(win_len), .cfg_num_win_i(num_win),
    .cnt_en_o(en), .cnt_clr_o(clr), .snap_valid_o(val), .snap_ready_i(ready),
    .snap_idx_o(idx), .snap_len_o(len), .snap_partial_o(part),
    .busy_o(busy), .cfg_err_o(err), .irq_o(irq), .irq_clr_i(iclr)
  );

  perf_window_ctrl #(.WIN_WIDTH(32), .NUM_WIDTH(2)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(w_start), .cfg_stop_i(w_stop),
    .cfg_win_len_i(w_win_len), .cfg_num_win_i(w_num_win),
    .cnt_en_o(w_en), .cnt_clr_o(w_clr), .snap_valid_o(w_val), .snap_ready_i(w_ready),
    .snap_idx_o(w_idx), .snap_len_o(w_len), .snap_partial_o(w_part),
    .busy_o(w_busy), .cfg_err_o(w_err), .irq_o(w_irq), .irq_clr_i(w_iclr)
  );

  typedef struct {
    logic start, stop, ready, iclr;
    int   wl, nw;
    logic en, clr, val, busy, irq, err;
    int   idx, len;
    logic part;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic s, st, rd, ic, input int wl, nw,
                             input logic e, c, vl, b, iq, er,
                             input int ix, ln, input logic p);
    vec_t r;
    r.start = s; r.stop = st; r.ready = rd; r.iclr = ic; r.wl = wl; r.nw = nw;
    r.en = e; r.clr = c; r.val = vl; r.busy = b; r.irq = iq; r.err = er;
    r.idx = ix; r.len = ln; r.part = p;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packs the observable outputs; snapshot fields only matter while valid.
  function automatic logic [63:0] pack(input logic e, c, vl, b, iq, er, p,
                                       input logic [15:0] ix, input logic [31:0] ln);
    if (!vl) begin
      p = 1'b0; ix = '0; ln = '0;
    end
    return {9'd0, e, c, vl, b, iq, er, p, ix, ln};
  endfunction

  function automatic logic [63:0] act_main();
    return pack(en, clr, val, busy, irq, err, part, idx, len);
  endfunction

  initial begin
    // basic run: win_len=4, num_win=2; cfg inputs change after start and must be ignored
    vt.push_back(v(1,0,1,0, 4,2, 0,1,0,1,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) vt.push_back(v(0,0,1,0, 9,5, 1,0,0,1,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 9,5, 0,0,1,1,0,0, 0,4,0));
    vt.push_back(v(0,0,1,0, 9,5, 0,1,0,1,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) vt.push_back(v(0,0,1,0, 9,5, 1,0,0,1,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 9,5, 0,0,1,1,0,0, 1,4,0));
    vt.push_back(v(0,0,1,0, 9,5, 0,0,0,1,1,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 9,5, 0,0,0,0,1,0, 0,0,0));
    vt.push_back(v(0,0,1,1, 9,5, 0,0,0,0,0,0, 0,0,0));
    // illegal config; err set beats simultaneous clear
    vt.push_back(v(1,0,1,1, 0,1, 0,0,0,0,0,1, 0,0,0));
    vt.push_back(v(0,0,1,0, 0,1, 0,0,0,0,0,1, 0,0,0));
    vt.push_back(v(0,0,1,1, 0,1, 0,0,0,0,0,0, 0,0,0));
    // start+stop together: nothing happens
    vt.push_back(v(1,1,1,0, 2,1, 0,0,0,0,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 2,1, 0,0,0,0,0,0, 0,0,0));
    // legal run after error clear; irq set beats simultaneous clear
    vt.push_back(v(1,0,1,0, 2,1, 0,1,0,1,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 2,1, 1,0,0,1,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 2,1, 1,0,0,1,0,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 2,1, 0,0,1,1,0,0, 0,2,0));
    vt.push_back(v(0,0,1,1, 2,1, 0,0,0,1,1,0, 0,0,0));
    vt.push_back(v(0,0,1,0, 2,1, 0,0,0,0,1,0, 0,0,0));
    vt.push_back(v(0,0,1,1, 2,1, 0,0,0,0,0,0, 0,0,0));

    // reset
    rst = 1'b1;
    step(); step();
    chk("reset_outputs", act_main(), 64'd0);
    chk("reset_wrap_outputs", {w_en, w_clr, w_val, w_busy, w_err, w_irq}, 64'd0);
    rst = 1'b0;

    foreach (vt[k]) begin
      start = vt[k].start; stop = vt[k].stop; ready = vt[k].ready; iclr = vt[k].iclr;
      win_len = 32'(vt[k].wl); num_win = 16'(vt[k].nw);
      step();
      chk($sformatf("vec%0d", k), act_main(),
          pack(vt[k].en, vt[k].clr, vt[k].val, vt[k].busy, vt[k].irq, vt[k].err,
               vt[k].part, 16'(vt[k].idx), 32'(vt[k].len)));
    end
    start = 0; stop = 0; iclr = 0;

    // back-pressure: win_len=3, num_win=1, ready low for 5 SNAP cycles
    ready = 0; win_len = 32'd3; num_win = 16'd1; start = 1;
    step(); start = 0;
    step(); step(); step(); step();
    chk("bp_snap_enter", act_main(), pack(0,0,1,1,0,0,0, 16'd0, 32'd3));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), act_main(), pack(0,0,1,1,0,0,0, 16'd0, 32'd3));
    end
    ready = 1;
    step();
    chk("bp_done", act_main(), pack(0,0,0,1,1,0,0, 16'd0, 32'd0));
    step();
    iclr = 1; step(); iclr = 0;

    // early stop in 4th RUN cycle, continuous mode
    win_len = 32'd10; num_win = 16'd0; start = 1;
    step(); start = 0;
    step(); step(); step(); step();
    chk("es_run4", act_main(), pack(1,0,0,1,0,0,0, 16'd0, 32'd0));
    stop = 1;
    step(); stop = 0;
    chk("es_snap", act_main(), pack(0,0,1,1,0,0,1, 16'd0, 32'd4));
    step();
    chk("es_done", act_main(), pack(0,0,0,1,1,0,0, 16'd0, 32'd0));
    begin
      logic act_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (clr || en || busy) act_seen = 1'b1;
      end
      chk("es_no_restart", {act_seen, irq}, {1'b0, 1'b1});
    end
    iclr = 1; step(); iclr = 0;

    // start during RUN is ignored
    win_len = 32'd3; num_win = 16'd1; start = 1;
    step(); start = 0;
    step();
    start = 1; win_len = 32'd8;
    step(); start = 0; win_len = 32'd3;
    chk("sr_run", act_main(), pack(1,0,0,1,0,0,0, 16'd0, 32'd0));
    step(); step();
    chk("sr_snap", act_main(), pack(0,0,1,1,0,0,0, 16'd0, 32'd3));
    step(); step();
    iclr = 1; step(); iclr = 0;

    // reset mid-RUN
    win_len = 32'd5; num_win = 16'd1; start = 1;
    step(); start = 0;
    step(); step();
    rst = 1;
    step(); rst = 0;
    chk("rst_mid_run", act_main(), 64'd0);
    for (int i = 0; i < 8; i++) step();
    chk("rst_no_irq", {busy, irq, en, val}, 64'd0);

    // continuous wrap on the 2-bit index instance
    begin
      logic [1:0] got[$];
      logic [1:0] exp_seq[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      int guard;
      w_win_len = 32'd1; w_num_win = 2'd0; w_ready = 1; w_start = 1;
      step(); w_start = 0;
      for (int i = 0; i < 60 && got.size() < 5; i++) begin
        step();
        if (w_val) got.push_back(w_idx);
      end
      chk("wrap_count", 64'(got.size()), 64'd5);
      for (int i = 0; i < 5; i++)
        chk($sformatf("wrap_idx%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hdead, 64'(exp_seq[i]));
      w_stop = 1; step(); w_stop = 0;
      guard = 0;
      while (w_busy && guard < 20) begin
        step();
        guard++;
      end
      chk("wrap_stop_idle", {w_busy, w_irq}, {1'b0, 1'b1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
